booth_dot_acc: RTL and testbench
================================

// Module: booth_dot_acc
// PURPOSE
//  Downstream consumer of the radix-4 Booth multiplier's (2N+1)-bit signed product.
//  Accumulates VEC_LEN consecutive products into one dot-product sum, then presents
//  it on a valid/ready output. Input also uses valid/ready, so it can follow a
//  registered multiplier stage.
// PARAMETERS
//  N        10  multiplier operand width; product input is 2N+1 bits, two's complement
//  VEC_LEN  8   products per dot product; >=1
//  ACC_W    24  accumulator/output width; >= 2N+1 (default 2N+1+$clog2(VEC_LEN))
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous reset, active low
//  flush      in   1        sync abort of current vector, highest priority
//  in_valid   in   1        in_prod valid
//  in_ready   out  1        block accepts in_prod this cycle
//  in_prod    in   2N+1     signed product from multiplier
//  out_valid  out  1        out_sum holds a finished dot product
//  out_ready  in   1        downstream accepts out_sum
//  out_sum    out  ACC_W    signed dot-product result
//  out_ovf    out  1        sticky overflow for the presented sum (ACC_SAT_EN only, else 0)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0.
//  - Input handshake: transfer when in_valid&&in_ready.
//    in_ready = (state==ACC) && !flush.
//  - Output handshake: transfer when out_valid&&out_ready.
//    out_sum/out_ovf stay stable while out_valid=1 and out_ready=0.
//  - in_prod is sign-extended to ACC_W before the add.
//  - FSM, 2 states:
//    ACC: each transfer does acc<=acc+prod, cnt<=cnt+1.
//         On the transfer with cnt==VEC_LEN-1: out_sum<=acc+prod, out_valid<=1,
//         acc<=0, cnt<=0, go OUT.
//    OUT: in_ready=0. On out_ready: out_valid<=0, go ACC.
//  - Latency: out_valid rises the cycle after the last product transfer.
//    With out_ready held at 1, back-to-back vectors lose one input cycle per vector
//    (the OUT cycle).
//  - VEC_LEN==1: every accepted product goes straight to OUT.
//  - flush=1: acc<=0, cnt<=0, out_valid<=0, out_ovf<=0, state<=ACC.
//    A pending out_sum is discarded even if out_ready=1 in the same cycle.
//    The input is not consumed that cycle.
//  - Reset mid-vector or mid-OUT: all state is cleared; partial sums are lost.
//  - Arithmetic wraps modulo 2^ACC_W unless ACC_SAT_EN is defined.
// CONFIGURATION
//  ACC_SAT_EN defined:
//   - Each add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//   - Signed overflow of any add in the vector sets an internal sticky flag.
//   - The flag is copied to out_ovf with out_sum, then cleared for the next vector.
//  ACC_SAT_EN undefined:
//   - Plain wrap-around add; out_ovf tied to 0; no saturation logic synthesised.
// STRUCTURE
//  - booth_pkg (shared with multiplier-side blocks):
//      typedef enum logic {ACC, OUT} acc_state_t;
//      function sext(), which sign-extends a product to ACC_W.
//  - Sub-module booth_sat_add: ACC_W-bit signed adder returning {sum, ovf}.
//    Saturating under ACC_SAT_EN, wrapping otherwise.
//  - Top level holds the FSM, counter ($clog2(VEC_LEN)+1 bits) and output registers.
// TESTING
//  1 Basic (N=10, VEC_LEN=4, out_ready=1): products 100,-30,7,0
//    -> out_sum=77 one cycle after the 4th transfer; out_valid high for 1 cycle.
//  2 Backpressure: hold out_ready=0 for 3 cycles after test 1's vector
//    -> out_sum=77 stable, in_ready=0 throughout; next vector starts only after accept.
//  3 Input bubbles: in_valid toggles 1,0,0,1,1,0,1 with products -5,-5,-5,-5
//    -> out_sum=-20; count advances only on transfers.
//  4 Flush: 2 products (500,500) then flush=1
//    -> next vector 1,1,1,1 gives out_sum=4. Flush during OUT drops the pending sum.
//  5 Async reset asserted mid-vector, between clock edges
//    -> out_valid=0, in_ready=1, out_sum=0 immediately; subsequent vector sums correctly.
//  6 Overflow (ACC_W=21, VEC_LEN=2): products 600000,600000.
//    With ACC_SAT_EN -> out_sum=1048575, out_ovf=1.
//    Without ACC_SAT_EN -> out_sum=-897152, out_ovf=0.

Source files
------------

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pkg
//  Purpose  : Shared types and helpers for the radix-4 Booth multiplier
//             family. Holds the dot-product accumulator state encoding and a
//             sign-extension helper for the (2N+1)-bit products.
//  Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Accumulator FSM: collecting products, or presenting a finished sum.
  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } acc_state_t;

  // Sign-extends the low from_w bits of val to 64 bits. Callers truncate the
  // result to their accumulator width. from_w must lie in 1..64.
  function automatic logic [63:0] sext(input logic [63:0] val, input int from_w);
    logic signed [63:0] t;
    int                 sh;
    sh = 64 - from_w;
    t  = $signed(val << sh);
    return t >>> sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_sat_add.sv
`default_nettype none
// ============================================================================
//  Module   : booth_sat_add
//  Purpose  : W-bit two's-complement adder for the dot-product accumulator.
//             With ACC_SAT_EN defined the result clamps to the signed range
//             and o_ovf flags signed overflow; otherwise the add wraps and
//             o_ovf is constant 0.
//  Ports    : i_a, i_b  in  W  signed operands
//             o_sum     out W  sum (saturated or wrapped)
//             o_ovf     out 1  signed overflow of this add
//  Macro    : ACC_SAT_EN
//  Revision : 1.0 - initial release
// ============================================================================
module booth_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  logic [W-1:0] w_raw;

  assign w_raw = i_a + i_b;

`ifdef ACC_SAT_EN
  logic w_ovf;

  // Overflow only when both operands share a sign and the result flips it.
  assign w_ovf = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);

  // Clamp toward the operands' sign: most negative or most positive value.
  assign o_sum = !w_ovf   ? w_raw :
                 i_a[W-1] ? {1'b1, {(W-1){1'b0}}} :
                            {1'b0, {(W-1){1'b1}}};
  assign o_ovf = w_ovf;
`else
  assign o_sum = w_raw;
  assign o_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/booth_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : booth_dot_acc
//  Purpose  : Accumulates VEC_LEN consecutive signed Booth products into one
//             dot-product sum and presents it on a valid/ready output.
//  Ports    : clk        in   1      rising-edge clock
//             rst_n      in   1      asynchronous reset, active low
//             flush      in   1      synchronous abort of current vector
//             in_valid   in   1      in_prod valid
//             in_ready   out  1      product accepted this cycle
//             in_prod    in   2N+1   signed product
//             out_valid  out  1      out_sum holds a finished dot product
//             out_ready  in   1      downstream accepts out_sum
//             out_sum    out  ACC_W  signed dot product
//             out_ovf    out  1      overflow seen while building out_sum
//  Macro    : ACC_SAT_EN - saturating accumulate with sticky overflow flag.
//             Undefined: wrap-around accumulate, out_ovf always 0.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_dot_acc
  import booth_pkg::*;
#(
  parameter int N       = 10,
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*N:0]         in_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic                 out_ovf
);

  localparam int PROD_W = 2 * N + 1;
  localparam int CNT_W  = $clog2(VEC_LEN) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(VEC_LEN - 1);

  acc_state_t       state_q,     state_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q,   out_sum_d;
  logic             out_ovf_q,   out_ovf_d;
  logic             sticky_q,    sticky_d;

  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_ovf;
  logic             w_in_fire;

  assign w_prod_ext = ACC_W'(sext(64'(in_prod), PROD_W));

  booth_sat_add #(
    .W (ACC_W)
  ) u_add (
    .i_a   (acc_q),
    .i_b   (w_prod_ext),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  assign in_ready  = (state_q == ACC) && !flush;
  assign w_in_fire = in_valid && in_ready;

  // Without ACC_SAT_EN the adder's overflow is constant 0, so the sticky and
  // out_ovf flops reduce to constants and out_ovf stays 0.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    sticky_d    = sticky_q;

    if (flush) begin
      // Abort wins over everything, including a same-cycle output accept.
      state_d     = ACC;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_ovf_d   = 1'b0;
      sticky_d    = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (w_in_fire) begin
            if (cnt_q == C_LAST) begin
              out_sum_d   = w_add_sum;
              out_ovf_d   = sticky_q | w_add_ovf;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              sticky_d    = 1'b0;
              state_d     = OUT;
            end else begin
              acc_d    = w_add_sum;
              cnt_d    = cnt_q + CNT_W'(1);
              sticky_d = sticky_q | w_add_ovf;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_dot_acc
//  Purpose  : Self-checking bench for booth_dot_acc. Main instance uses
//             N=10, VEC_LEN=4, ACC_W=24; a second instance (ACC_W=21,
//             VEC_LEN=2) exercises accumulator overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_dot_acc;

  typedef struct packed {
    logic [23:0] sum;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic        out_ovf;

  logic        in_valid6;
  logic        in_ready6;
  logic [20:0] in_prod6;
  logic        out_valid6;
  logic        out_ready6;
  logic [20:0] out_sum6;
  logic        out_ovf6;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  booth_dot_acc #(.N(10), .VEC_LEN(4), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  booth_dot_acc #(.N(10), .VEC_LEN(2), .ACC_W(21)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_prod(in_prod6),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .out_sum(out_sum6), .out_ovf(out_ovf6)
  );

  // Scoreboard: every output handshake of the main instance pops one entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got out_sum=%0d, expected no output", $signed(out_sum));
        end else begin
          e = sb.pop_front();
          if (out_sum !== e.sum || out_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL sb_result: got sum=%0d ovf=%0b, expected sum=%0d ovf=%0b",
                     $signed(out_sum), out_ovf, $signed(e.sum), e.ovf);
          end
        end
      end
    end
  end

  // Drives one product and holds it until the DUT takes it (bounded).
  task automatic send(input int p);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_prod  = 21'(p);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: product %0d never accepted, expected acceptance", p);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
    in_valid6 = 1'b0; in_prod6 = '0; out_ready6 = 1'b1;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 24'd0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b sum=%0d ovf=%0b ready=%0b, expected 0 0 0 1",
               out_valid, $signed(out_sum), out_ovf, in_ready);
    end
    n_checks++;
    if (out_valid6 !== 1'b0 || out_sum6 !== 21'd0 || in_ready6 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state6: got valid=%0b sum=%0d ready=%0b, expected 0 0 1",
               out_valid6, $signed(out_sum6), in_ready6);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    sb.push_back('{sum: 24'(77), ovf: 1'b0});
    send(100); send(-30); send(7); send(0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'(77)) begin
      n_fail++;
      $display("FAIL basic_latency: got valid=%0b sum=%0d, expected valid=1 sum=77",
               out_valid, $signed(out_sum));
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_pulse: got valid=%0b, expected 0", out_valid);
    end
    idle(1);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    sb.push_back('{sum: 24'(77), ovf: 1'b0});
    send(100); send(-30); send(7); send(0);
    // Offer a product while the sum is held; it must not be taken.
    in_valid = 1'b1;
    in_prod  = 21'(9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 24'(77) || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got valid=%0b sum=%0d ready=%0b, expected 1 77 0",
                 i, out_valid, $signed(out_sum), in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    sb.push_back('{sum: 24'(36), ovf: 1'b0});
    send(9); send(9); send(9); send(9);
    idle(2);
  endtask

  task automatic test_bubbles;
    logic [6:0] pat;
    int         seen;
    pat  = 7'b1011001;
    seen = 0;
    sb.push_back('{sum: 24'(-20), ovf: 1'b0});
    in_prod = 21'(-5);
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bubbles_early[%0d]: got valid=%0b, expected 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bubbles_done: got valid=%0b, expected 1", out_valid);
    end
    seen = seen + 1;
    idle(2);
  endtask

  task automatic test_flush;
    send(500); send(500);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 21'(1);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %0b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.push_back('{sum: 24'(4), ovf: 1'b0});
    send(1); send(1); send(1); send(1);
    idle(2);
    // Flush while a sum is pending, with out_ready raised in the same cycle.
    out_ready = 1'b0;
    send(2); send(2); send(2); send(2);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_out_pending: got valid=%0b, expected 1", out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: got valid=%0b, expected 0", out_valid);
    end
    @(posedge clk); #1;
    sb.push_back('{sum: 24'(12), ovf: 1'b0});
    send(3); send(3); send(3); send(3);
    idle(2);
  endtask

  task automatic test_async_reset;
    send(50); send(50);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 24'd0) begin
      n_fail++;
      $display("FAIL areset_mid_vec: got valid=%0b ready=%0b sum=%0d, expected 0 1 0",
               out_valid, in_ready, $signed(out_sum));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{sum: 24'(26), ovf: 1'b0});
    send(5); send(6); send(7); send(8);
    idle(2);
    // Reset while a sum is being presented.
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_pre_out: got valid=%0b ready=%0b, expected 1 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 24'd0) begin
      n_fail++;
      $display("FAIL areset_mid_out: got valid=%0b ready=%0b sum=%0d, expected 0 1 0",
               out_valid, in_ready, $signed(out_sum));
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    logic [20:0] exp_sum;
    logic        exp_ovf;
`ifdef ACC_SAT_EN
    exp_sum = 21'(1048575);
    exp_ovf = 1'b1;
`else
    exp_sum = 21'(-897152);
    exp_ovf = 1'b0;
`endif
    in_valid6 = 1'b1;
    in_prod6  = 21'(600000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready6 !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_in_ready[%0d]: got %0b, expected 1", i, in_ready6);
      end
      @(posedge clk); #1;
    end
    in_valid6 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid6 !== 1'b1 || out_sum6 !== exp_sum || out_ovf6 !== exp_ovf) begin
      n_fail++;
      $display("FAIL ovf_result: got valid=%0b sum=%0d ovf=%0b, expected 1 %0d %0b",
               out_valid6, $signed(out_sum6), out_ovf6, $signed(exp_sum), exp_ovf);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_async_reset();
    test_overflow();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d outstanding results, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
